// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared defaults and the fetch state type for instruction_fetch.
package ifetch_pkg;
  localparam int IF_ADDR_W = 8;
  localparam int IF_DATA_W = 16;
  localparam logic [7:0] IF_RESET_PC = 8'h00;
  typedef enum logic {S_FETCH = 1'b0, S_HALTED = 1'b1} state_t;
endpackage

// File: rtl/ifetch_fifo.sv
// ifetch_fifo: circular instruction buffer with push/pop/flush and occupancy count.
module ifetch_fifo #(
  parameter int W     = 24,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  input  logic          flush,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] rd, wr;
  assign dout = mem[rd];
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wr] <= din;
        wr <= wr + PW'(1);
      end
      if (pop) rd <= rd + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC sequencer feeding a small buffer from a 1-cycle-latency memory.
// Optional macro IFETCH_PERF_CNT_EN adds a saturating fetch_count of completed handshakes.
module instruction_fetch
  import ifetch_pkg::*;
#(
  parameter int                ADDR_W    = IF_ADDR_W,
  parameter int                DATA_W    = IF_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(IF_RESET_PC),
  parameter int                BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  input  logic              branch_valid,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              halt,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_pc
`ifdef IFETCH_PERF_CNT_EN
  , output logic [15:0]     fetch_count
`endif
);
  localparam int CW = $clog2(BUF_DEPTH) + 1;
  state_t state;
  logic [ADDR_W-1:0] pc, fl_pc;
  logic inflight, pop, push, issue;
  logic [CW-1:0] count;
  logic [CW:0] occ;
  assign imem_addr = pc;
  assign instr_valid = count != '0;
  assign pop = instr_valid & instr_ready;
  assign push = inflight & ~branch_valid;
  // occupancy counts the head leaving this cycle so a full stream sustains one per cycle
  assign occ = (CW+1)'(count) + (CW+1)'(inflight) - (CW+1)'(pop);
  assign issue = state == S_FETCH && !halt && !branch_valid && occ < (CW+1)'(BUF_DEPTH);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_FETCH;
      pc <= RESET_PC;
      fl_pc <= '0;
      inflight <= 1'b0;
    end else begin
      state <= halt ? S_HALTED : S_FETCH;
      pc <= branch_valid ? {branch_target[ADDR_W-1:1], 1'b0} : issue ? pc + ADDR_W'(2) : pc;
      inflight <= issue;
      if (issue) fl_pc <= pc;
    end
  end
  ifetch_fifo #(.W(ADDR_W + DATA_W), .DEPTH(BUF_DEPTH), .CW(CW)) u_fifo (
    .clk(clk),
    .reset_n(reset_n),
    .push(push),
    .din({fl_pc, imem_data}),
    .pop(pop),
    .flush(branch_valid),
    .dout({instr_pc, instr_data}),
    .count(count)
  );
`ifdef IFETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) fetch_count <= '0;
    else if (pop && fetch_count != 16'hFFFF) fetch_count <= fetch_count + 16'd1;
  end
`endif
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed tables plus random traffic against a sequence-level model.
module tb_instruction_fetch;
  logic clk = 1'b0, reset_n = 1'b0;
  logic [7:0] imem_addr, branch_target = '0, instr_pc;
  logic [15:0] imem_data = '0, instr_data;
  logic branch_valid = 1'b0, halt = 1'b0, instr_valid, instr_ready = 1'b0;
`ifdef IFETCH_PERF_CNT_EN
  logic [15:0] fetch_count;
`endif
  int total = 0, bad = 0, hs = 0;
  logic [7:0] exp_pc = 8'h00, prev_pc = '0, prev_addr = '0;
  logic [15:0] prev_data = '0;
  bit prev_hold = 0, prev_branch = 0, prev_halt = 0;

  typedef struct {logic [7:0] tgt; logic [7:0] p0; logic [7:0] p1;} br_t;
  br_t tbl [5];

  instruction_fetch dut (
    .clk(clk), .reset_n(reset_n), .imem_addr(imem_addr), .imem_data(imem_data),
    .branch_valid(branch_valid), .branch_target(branch_target), .halt(halt),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_data(instr_data),
    .instr_pc(instr_pc)
`ifdef IFETCH_PERF_CNT_EN
    , .fetch_count(fetch_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_f(input logic [7:0] a);
    return {a, a ^ 8'hA5};
  endfunction

  always @(posedge clk) imem_data <= mem_f(imem_addr);

  task automatic chk(input bit ok, input string name, input int act, input int req);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!instr_valid && n < 10) begin
      step();
      n++;
    end
    chk(instr_valid, "wait_valid", int'(instr_valid), 1);
  endtask

  // expected delivery order: sequential by 2 from reset or the last branch target
  always @(negedge clk) begin
    if (!reset_n) begin
      exp_pc = 8'h00;
      hs = 0;
      prev_hold = 0;
      prev_branch = 0;
      prev_halt = 0;
    end else begin
      if (prev_hold)
        chk(instr_valid && instr_pc == prev_pc && instr_data == prev_data, "hold",
            {instr_valid, instr_pc, instr_data}, {1'b1, prev_pc, prev_data});
      if (prev_branch) chk(!instr_valid, "flush", int'(instr_valid), 0);
      if (prev_halt) chk(imem_addr == prev_addr, "halt_issue", imem_addr, prev_addr);
      if (instr_valid && instr_ready) begin
        chk(instr_pc == exp_pc, "seq_pc", instr_pc, exp_pc);
        chk(instr_data == mem_f(instr_pc), "seq_data", instr_data, mem_f(instr_pc));
        exp_pc = exp_pc + 8'd2;
        hs++;
      end
      if (branch_valid) exp_pc = {branch_target[7:1], 1'b0};
      prev_hold = instr_valid && !instr_ready && !branch_valid;
      prev_pc = instr_pc;
      prev_data = instr_data;
      prev_branch = branch_valid;
      prev_halt = halt && !branch_valid;
      prev_addr = imem_addr;
    end
  end

  initial begin
    logic [7:0] a0, d;
    int h0;
    tbl[0] = '{8'h41, 8'h40, 8'h42};
    tbl[1] = '{8'hFE, 8'hFE, 8'h00};
    tbl[2] = '{8'h00, 8'h00, 8'h02};
    tbl[3] = '{8'h7F, 8'h7E, 8'h80};
    tbl[4] = '{8'hFD, 8'hFC, 8'hFE};
    #2;
    chk(!instr_valid, "rst_valid", int'(instr_valid), 0);
    chk(instr_pc == 8'h00, "rst_pc", instr_pc, 0);
    chk(instr_data == 16'h0, "rst_data", instr_data, 0);
    chk(imem_addr == 8'h00, "rst_addr", imem_addr, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    instr_ready = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      chk(imem_addr == 8'(2 * k), "stream_addr", imem_addr, 2 * k);
      if (k >= 2) chk(instr_valid && instr_pc == 8'(2 * (k - 2)), "stream_pc", instr_pc, 2 * (k - 2));
    end
    instr_ready = 1'b0;
    a0 = imem_addr;
    repeat (5) step();
    d = imem_addr - a0;
    chk(d <= 8'd4, "stall_issue", d, 4);
    instr_ready = 1'b1;
    repeat (4) step();
    halt = 1'b1;
    h0 = hs;
    repeat (6) step();
    chk(hs - h0 >= 1 && hs - h0 <= 2, "halt_drain", hs - h0, 2);
    chk(!instr_valid, "halt_empty", int'(instr_valid), 0);
    halt = 1'b0;
    wait_valid();
    repeat (3) step();
    foreach (tbl[i]) begin
      instr_ready = 1'b0;
      repeat (3) step();
      chk(instr_valid, "br_full", int'(instr_valid), 1);
      branch_valid = 1'b1;
      branch_target = tbl[i].tgt;
      step();
      branch_valid = 1'b0;
      instr_ready = 1'b1;
      chk(!instr_valid, "br_flush", int'(instr_valid), 0);
      wait_valid();
      chk(instr_pc == tbl[i].p0, "br_pc0", instr_pc, tbl[i].p0);
      step();
      chk(instr_valid && instr_pc == tbl[i].p1, "br_pc1", instr_pc, tbl[i].p1);
    end
    for (int c = 0; c < 1500; c++) begin
      instr_ready = ($urandom % 4) != 0;
      if ($urandom % 20 == 0) halt = !halt;
      branch_valid = ($urandom % 25) == 0;
      branch_target = 8'($urandom);
      step();
    end
    branch_valid = 1'b0;
    halt = 1'b0;
    instr_ready = 1'b1;
    repeat (10) step();
`ifdef IFETCH_PERF_CNT_EN
    chk(fetch_count == 16'(hs), "perf_count", fetch_count, hs);
`endif
    reset_n = 1'b0;
    #1;
    chk(!instr_valid, "mid_rst_valid", int'(instr_valid), 0);
    chk(instr_pc == 8'h00 && instr_data == 16'h0, "mid_rst_head", {instr_pc, instr_data}, 0);
    chk(imem_addr == 8'h00, "mid_rst_addr", imem_addr, 0);
`ifdef IFETCH_PERF_CNT_EN
    chk(fetch_count == 16'h0, "mid_rst_perf", fetch_count, 0);
`endif
    repeat (2) step();
    reset_n = 1'b1;
    wait_valid();
    chk(instr_pc == 8'h00, "rst_restart", instr_pc, 0);
    repeat (8) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
